wb_master: RTL

WB_MASTER -- requirements
Module: wb_master

---
 rtl/wb_master.sv | 128 ++++++++++++
 1 files changed

// File: rtl/wb_master.sv
// Single-outstanding Wishbone classic master: one command in, one bus cycle out, one completion pulse back.
// Optional bus watchdog enabled by defining WB_MASTER_TIMEOUT_EN.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module wb_master #(
    parameter int ADDR_WIDTH     = `ADDR_WIDTH,
    parameter int DATA_WIDTH     = `DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_we_i,
    input  logic [ADDR_WIDTH-1:0] cmd_adr_i,
    input  logic [DATA_WIDTH-1:0] cmd_dat_i,
    output logic                  rsp_valid_o,
    output logic [DATA_WIDTH-1:0] rsp_dat_o,
    output logic                  rsp_err_o,
    output logic [ADDR_WIDTH-1:0] adr_o,
    output logic [DATA_WIDTH-1:0] dat_o,
    input  logic [DATA_WIDTH-1:0] dat_i,
    output logic                  we_o,
    output logic                  cyc_o,
    output logic                  stb_o,
    input  logic                  ack_i,
    input  logic                  err_i
);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("wb_master: TIMEOUT_CYCLES must be in 2..255");
    end

    typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

    state_t state, state_nxt;
    logic   accept, fin_ack, fin_err;
    logic   timeout_hit;
    logic   err_q;

`ifdef WB_MASTER_TIMEOUT_EN
    logic [7:0] tmo_cnt;

    // Counts BUS cycles that end without a slave response; cleared outside BUS.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)
            tmo_cnt <= 8'd0;
        else if (state != BUS)
            tmo_cnt <= 8'd0;
        else if (!ack_i && !err_i)
            tmo_cnt <= tmo_cnt + 8'd1;
    end

    assign timeout_hit = (state == BUS) && !ack_i && !err_i &&
                         (tmo_cnt == 8'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // ack wins over err when both arrive together.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        fin_ack   = 1'b0;
        fin_err   = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid_i) begin
                    accept    = 1'b1;
                    state_nxt = BUS;
                end
            end
            BUS: begin
                if (ack_i) begin
                    fin_ack   = 1'b1;
                    state_nxt = DONE;
                end else if (err_i || timeout_hit) begin
                    fin_err   = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            adr_o     <= '0;
            dat_o     <= '0;
            we_o      <= 1'b0;
            rsp_dat_o <= '0;
            err_q     <= 1'b0;
        end else begin
            if (accept) begin
                adr_o <= cmd_adr_i;
                dat_o <= cmd_dat_i;
                we_o  <= cmd_we_i;
            end
            if (fin_ack && !we_o)
                rsp_dat_o <= dat_i;
            if (fin_ack)
                err_q <= 1'b0;
            else if (fin_err)
                err_q <= 1'b1;
        end
    end

    // Handshake and bus strobes decode straight from the state register, so reset drops them at once.
    assign cmd_ready_o = (state == IDLE);
    assign cyc_o       = (state == BUS);
    assign stb_o       = (state == BUS);
    assign rsp_valid_o = (state == DONE);
    assign rsp_err_o   = err_q;

endmodule
